mul: RTL and testbench
======================

MUL -- requirements
Module: mul

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; output width is 2*WIDTH.
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 a_bi  input  WIDTH  unsigned multiplicand.
REQ-005 b_bi  input  WIDTH  unsigned multiplier.
REQ-006 start_i  input  1  level request to begin a multiplication; sampled only in IDLE.
REQ-007 busy_o  output  1  high while a multiplication is in progress.
REQ-008 y_bo  output  2*WIDTH  registered unsigned product of the last completed operation.

Function
REQ-009 The block SHALL be a sequential shift-add multiplier with FSM states IDLE and WORK.
REQ-010 In IDLE with start_i=1 at a rising edge, it SHALL latch a_bi and b_bi, clear the partial sum and bit counter, and enter WORK.
REQ-011 In IDLE with start_i=0, it SHALL stay in IDLE with all registers unchanged.
REQ-012 Each WORK cycle SHALL add (latched a << counter) to the partial sum when latched b[counter]=1, then increment the counter.
REQ-013 After exactly WIDTH WORK cycles, the final sum SHALL be written to y_bo and the FSM SHALL return to IDLE on that same edge.
REQ-014 busy_o SHALL be high exactly in WORK: WIDTH cycles per operation, 8 cycles at the default width.
REQ-015 Latency SHALL be WIDTH+1 rising edges from the start-sampling edge to a valid y_bo; y_bo SHALL be valid within 10 clocks at WIDTH=8.
REQ-016 The product SHALL be exact unsigned a*b with no truncation; the maximum is (2^WIDTH-1)^2.
REQ-017 y_bo SHALL hold its previous value during WORK and change only on the completion edge.
REQ-018 start_i and operand changes during WORK SHALL be ignored.
REQ-019 start_i held continuously high SHALL restart on the first IDLE cycle with current operands, giving back-to-back operations separated by one IDLE cycle.

Reset
REQ-020 rst_i=0 SHALL immediately force state IDLE, busy_o=0, y_bo=0, and clear the counter, partial sum and latched operands.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no partial result on y_bo.
REQ-022 After rst_i deasserts, the first operation SHALL start on the first edge with start_i=1.

Configuration
REQ-023 Macro MUL_DONE_PULSE_EN defined: add output done_o (1 bit), high for exactly one cycle following the completion edge (REQ-013) and 0 in reset.
REQ-024 Macro MUL_DONE_PULSE_EN undefined: no done_o port; behaviour is otherwise identical.

Structure
REQ-025 Shared package mul_pkg SHALL hold the default WIDTH constant, the FSM state typedef (IDLE, WORK) and the counter width constant ($clog2(WIDTH)+1).
REQ-026 The FSM and counter SHALL be in one sub-module, mul_ctrl; the shift-add datapath, operand registers and y_bo register stay in mul.

Verification
REQ-027 a=0, b=0 from IDLE -> busy_o high for 8 cycles, then y_bo=0.
REQ-028 Sweep a=b=i for i=0..9, each from fresh reset with start tied high -> y_bo=i*i (0,1,4,...,81) within 10 clocks.
REQ-029 a=255, b=255 -> y_bo=65025; a=255, b=1 -> y_bo=255; a=1, b=255 -> y_bo=255.
REQ-030 a=3, b=5 start; change to a=7, b=7 and pulse start during WORK -> y_bo=15, and no second operation starts until IDLE.
REQ-031 Reset asserted at the 4th WORK cycle of a=200, b=200 -> busy_o=0 and y_bo=0 at once; y_bo stays 0 until a new start.
REQ-032 With MUL_DONE_PULSE_EN defined, a=12, b=11 -> y_bo=132, with done_o high for exactly one cycle.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
// The optional done pulse output is controlled by the MUL_DONE_PULSE_EN macro (see mul.sv).
package mul_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    // The counter must be able to reach WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_ctrl.sv
// Control FSM and bit counter for the shift-add multiplier: sequences IDLE/WORK
// and tells the datapath when to load operands, accumulate and commit the result.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          busy,
    output logic          load,
    output logic          step,
    output logic          finish,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = WORK;
                    cnt_next   = '0;
                    load       = 1'b1;
                end
            end
            WORK: begin
                step     = 1'b1;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == LAST_CNT) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == WORK);
    assign cnt  = cnt_reg;

endmodule

// File: rtl/mul.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock.
// Define MUL_DONE_PULSE_EN to add a one-cycle done_o pulse after each completion.
module mul
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   a_bi,
    input  logic [WIDTH-1:0]   b_bi,
    input  logic               start_i,
    output logic               busy_o,
`ifdef MUL_DONE_PULSE_EN
    output logic               done_o,
`endif
    output logic [2*WIDTH-1:0] y_bo
);

    localparam int CW = cnt_width(WIDTH);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic          busy;
    logic          load;
    logic          step;
    logic          finish;
    logic [CW-1:0] cnt;

    mul_ctrl #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_ctrl (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .busy    (busy),
        .load    (load),
        .step    (step),
        .finish  (finish),
        .cnt     (cnt)
    );

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] sum_reg;
    logic [2*WIDTH-1:0] y_reg;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum_next;
    logic [IW-1:0]      bit_idx;

    // The counter never exceeds WIDTH-1 while stepping, so its low bits index b.
    assign bit_idx  = cnt[IW-1:0];
    assign addend   = b_reg[bit_idx] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : '0;
    assign sum_next = sum_reg + addend;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            y_reg   <= '0;
        end else begin
            if (load) begin
                a_reg   <= a_bi;
                b_reg   <= b_bi;
                sum_reg <= '0;
            end else if (step) begin
                sum_reg <= sum_next;
            end
            if (finish) begin
                y_reg <= sum_next;
            end
        end
    end

`ifdef MUL_DONE_PULSE_EN
    logic done_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= finish;
        end
    end

    assign done_o = done_reg;
`endif

    assign busy_o = busy;
    assign y_bo   = y_reg;

endmodule

// File: tb/tb_mul.sv
// Randomized self-checking bench for mul against a plain a*b reference.
// Build with MUL_DONE_PULSE_EN defined to also check the done pulse.
module tb_mul;

    localparam int W = 8;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [W-1:0]   a_bi;
    logic [W-1:0]   b_bi;
    logic           start_i;
    logic           busy_o;
    logic [2*W-1:0] y_bo;
`ifdef MUL_DONE_PULSE_EN
    logic           done_o;
`endif

    int             vectors     = 0;
    int             miscompares = 0;
    logic [2*W-1:0] model_y;
    bit             scramble;

    always #5 clk_i = ~clk_i;

    mul #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
`ifdef MUL_DONE_PULSE_EN
        .done_o  (done_o),
`endif
        .y_bo    (y_bo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i   = 1'b0;
        start_i = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_y", {48'd0, y_bo}, 64'd0);
`ifdef MUL_DONE_PULSE_EN
        check("rst_done", {63'd0, done_o}, 64'd0);
`endif
        model_y = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Called just after a start-sampling edge; counts WORK cycles (bounded).
    task automatic wait_op(output int cycles);
        cycles = 0;
        while (busy_o === 1'b1 && cycles < 20) begin
            check("y_hold", {48'd0, y_bo}, {48'd0, model_y});
            if (scramble) begin
                a_bi    = W'($urandom);
                b_bi    = W'($urandom);
                start_i = 1'($urandom);
            end
            @(posedge clk_i);
            #1;
            cycles++;
        end
        if (scramble) start_i = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int cyc;
        @(negedge clk_i);
        a_bi    = a;
        b_bi    = b;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_op(cyc);
        check({tag, "_busy_cycles"}, 64'(cyc), 64'(W));
        model_y = (2*W)'(a) * (2*W)'(b);
        check({tag, "_y"}, {48'd0, y_bo}, {48'd0, model_y});
        $display("op %s a=%0d b=%0d y=%0d busy_cycles=%0d", tag, a, b, y_bo, cyc);
`ifdef MUL_DONE_PULSE_EN
        check({tag, "_done_hi"}, {63'd0, done_o}, 64'd1);
        @(posedge clk_i);
        #1;
        check({tag, "_done_lo"}, {63'd0, done_o}, 64'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_i    = 1'b0;
        start_i  = 1'b0;
        a_bi     = '0;
        b_bi     = '0;
        model_y  = '0;
        scramble = 1'b0;
        repeat (2) @(negedge clk_i);
        do_reset();

        // Idle with start low must leave everything untouched.
        repeat (3) @(posedge clk_i);
        #1;
        check("idle_busy", {63'd0, busy_o}, 64'd0);
        check("idle_y", {48'd0, y_bo}, 64'd0);

        run_op(8'd0, 8'd0, "zero");

        for (int i = 0; i < 10; i++) begin
            do_reset();
            run_op(W'(i), W'(i), "sweep");
        end

        run_op(8'd255, 8'd255, "max");
        run_op(8'd255, 8'd1, "a255b1");
        run_op(8'd1, 8'd255, "a1b255");
        run_op(8'd12, 8'd11, "done_case");

        // Operand and start changes during WORK must be ignored.
        scramble = 1'b1;
        run_op(8'd3, 8'd5, "ignore_work");
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), "rand");
        end
        scramble = 1'b0;

        // Start held high: back-to-back with one idle cycle between.
        @(negedge clk_i);
        a_bi    = 8'd5;
        b_bi    = 8'd6;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        wait_op(cyc);
        check("b2b1_busy_cycles", 64'(cyc), 64'(W));
        model_y = 16'd30;
        check("b2b1_y", {48'd0, y_bo}, {48'd0, model_y});
        check("b2b_idle_gap", {63'd0, busy_o}, 64'd0);
        a_bi = 8'd9;
        b_bi = 8'd10;
        @(posedge clk_i);
        #1;
        check("b2b_restart", {63'd0, busy_o}, 64'd1);
        wait_op(cyc);
        start_i = 1'b0;
        check("b2b2_busy_cycles", 64'(cyc), 64'(W));
        model_y = 16'd90;
        check("b2b2_y", {48'd0, y_bo}, {48'd0, model_y});
        $display("op b2b a=9 b=10 y=%0d busy_cycles=%0d", y_bo, cyc);

        // Reset in the 4th WORK cycle aborts without a partial result.
        @(negedge clk_i);
        a_bi    = 8'd200;
        b_bi    = 8'd200;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_y", {48'd0, y_bo}, 64'd0);
        model_y = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #1;
            check("abort_hold_y", {48'd0, y_bo}, 64'd0);
            check("abort_hold_busy", {63'd0, busy_o}, 64'd0);
        end
        $display("op abort a=200 b=200 y=%0d busy=%0d", y_bo, busy_o);

        run_op(8'd200, 8'd200, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
